prefetch_queue_responder: RTL and testbench

Serves the refill side of the L1 stream buffers: arbitrates among stream-buffer prefetch requests, captures each granted request address into a 2^P-entry circular prefetch queue, issues queued addresses to L2 over a valid/ready handshake, and routes each in-order L2 response back to its owning stream buffer as a one-cycle commit pulse with data. It sits between the bank of stream-buffer controllers and the L2 request/response port.

---
 rtl/prefetch_queue_responder_pkg.sv | 34 +++
 rtl/prefetch_queue_responder_arbiter.sv | 71 +++++++
 rtl/prefetch_queue_responder.sv | 148 ++++++++++++++
 tb/tb_prefetch_queue_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | prefetch_queue_responder_pkg                                           |
// | Shared types and constants for the prefetch queue responder: queue     |
// | entry layout {addr, owner id}, pointer width, buffer count and a       |
// | helper turning an owner id into a one-hot buffer vector.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package prefetch_queue_responder_pkg;

  localparam int PQ_ADDR_WIDTH = 5;
  localparam int PQ_DATA_WIDTH = 256;
  localparam int PQ_P          = 2;
  localparam int PQ_B          = 2;
  localparam int PQ_NBUF       = 2 ** PQ_B;
  localparam int PQ_PTR_W      = PQ_P + 1;
  localparam int PQ_ID_W       = PQ_B;

  // Queue entry. Field widths follow the package constants, so a build
  // that changes the address width or buffer count does so here.
  typedef struct packed {
    logic [PQ_ADDR_WIDTH-1:0] addr;
    logic [PQ_ID_W-1:0]       id;
  } pq_entry_t;

  function automatic logic [PQ_NBUF-1:0] id_to_onehot(input logic [PQ_ID_W-1:0] id);
    logic [PQ_NBUF-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage : prefetch_queue_responder_pkg
`default_nettype wire

// File: rtl/prefetch_queue_responder_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | prefetch_arbiter                                                       |
// | Picks at most one eligible stream buffer per cycle.                    |
// | Ports:                                                                 |
// |   clk, rst_n  clock / async active-low reset (round-robin build only)  |
// |   enable      grant permitted this cycle                               |
// |   eligible    per-buffer request vector (cooldown already applied)     |
// |   grant       one-hot grant, combinational                             |
// | Macro PREFETCH_QUEUE_RR_EN: round-robin; otherwise fixed priority.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module prefetch_arbiter
  import prefetch_queue_responder_pkg::*;
#(
  parameter int B = PQ_B,
  localparam int NBUF = 2 ** B
) (
`ifdef PREFETCH_QUEUE_RR_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic            enable,
  input  logic [NBUF-1:0] eligible,
  output logic [NBUF-1:0] grant
);

`ifdef PREFETCH_QUEUE_RR_EN
  // ptr is where the next search begins: one above the last winner.
  logic [B-1:0] ptr;
  logic [B-1:0] idx;
  logic [B-1:0] win_idx;
  logic         found;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = ptr;
    idx     = '0;
    for (int k = 0; k < NBUF; k++) begin
      // NBUF is a power of two, so B-bit addition wraps for free.
      idx = ptr + B'(k);
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (enable && found) begin
      grant[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= win_idx + B'(1);
    end
  end
`else
  // Lowest set bit wins.
  always_comb begin
    grant = '0;
    if (enable) begin
      grant = eligible & (~eligible + NBUF'(1));
    end
  end
`endif

endmodule : prefetch_arbiter
`default_nettype wire

// File: rtl/prefetch_queue_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | prefetch_queue_responder                                               |
// | Arbitrates stream-buffer prefetch requests into a 2^P-entry circular   |
// | queue, issues queued line addresses to L2 (valid/ready) and routes     |
// | in-order L2 responses back to the owning buffer as a one-cycle commit  |
// | pulse with data.                                                       |
// | Ports:                                                                 |
// |   CLK, RSTN               clock, async active-low reset                |
// |   ENB                     global enable, low freezes all state         |
// |   SB_PREFETCH_VALID       per-buffer prefetch request                  |
// |   SB_NEXT_REQ             per-buffer next line address (packed)        |
// |   SB_PREFETCH_REQUESTED   one-hot grant (combinational)                |
// |   SB_PREFETCH_COMMITED    one-hot response pulse (registered)          |
// |   REFILL_DATA             line data with the commit pulse              |
// |   L2_REQ_VALID/READY/ADDR L2 request handshake                         |
// |   L2_RESP_VALID/DATA      in-order L2 response                         |
// |   PROTOCOL_ERR            sticky: response with nothing outstanding    |
// | Macro PREFETCH_QUEUE_RR_EN selects round-robin arbitration.            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module prefetch_queue_responder
  import prefetch_queue_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = PQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = PQ_DATA_WIDTH,
  parameter int P          = PQ_P,
  parameter int B          = PQ_B,
  localparam int NBUF      = 2 ** B
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       ENB,
  input  logic [NBUF-1:0]            SB_PREFETCH_VALID,
  input  logic [NBUF*ADDR_WIDTH-1:0] SB_NEXT_REQ,
  output logic [NBUF-1:0]            SB_PREFETCH_REQUESTED,
  output logic [NBUF-1:0]            SB_PREFETCH_COMMITED,
  output logic [DATA_WIDTH-1:0]      REFILL_DATA,
  output logic                       L2_REQ_VALID,
  input  logic                       L2_REQ_READY,
  output logic [ADDR_WIDTH-1:0]      L2_REQ_ADDR,
  input  logic                       L2_RESP_VALID,
  input  logic [DATA_WIDTH-1:0]      L2_RESP_DATA,
  output logic                       PROTOCOL_ERR
);

  pq_entry_t queue_mem [2**P];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [P:0]            wr_ptr;
  logic [P:0]            iss_ptr;
  logic [P:0]            ret_ptr;
  logic [P:0]            occupancy;
  logic                  full;
  logic                  issuable;
  logic                  outstanding;
  logic [NBUF-1:0]       cooldown;
  logic [NBUF-1:0]       eligible;
  logic [NBUF-1:0]       grant;
  logic [B-1:0]          grant_id;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  issue_fire;
  logic                  resp_fire;
  logic                  resp_stray;

  assign occupancy   = wr_ptr - ret_ptr;
  // Full is judged on registered pointers only; a retire in the same
  // cycle does not open a slot until the next one.
  assign full        = (occupancy == {1'b1, {P{1'b0}}});
  assign issuable    = (iss_ptr != wr_ptr);
  assign outstanding = (ret_ptr != iss_ptr);

  // A buffer's next address lags its grant by two cycles, so it sits out
  // the cycle right after being granted.
  assign eligible = SB_PREFETCH_VALID & ~cooldown;

  prefetch_arbiter #(
    .B (B)
  ) u_arbiter (
`ifdef PREFETCH_QUEUE_RR_EN
    .clk      (CLK),
    .rst_n    (RSTN),
`endif
    .enable   (ENB && !full),
    .eligible (eligible),
    .grant    (grant)
  );

  assign SB_PREFETCH_REQUESTED = grant;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (grant[i]) begin
        grant_id = B'(i);
      end
    end
  end

  assign grant_addr = SB_NEXT_REQ[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];

  assign L2_REQ_VALID = ENB && issuable;
  assign L2_REQ_ADDR  = queue_mem[iss_ptr[P-1:0]].addr;
  assign issue_fire   = L2_REQ_VALID && L2_REQ_READY;
  assign resp_fire    = ENB && L2_RESP_VALID && outstanding;
  assign resp_stray   = ENB && L2_RESP_VALID && !outstanding;

  // Entry storage needs no reset: it is only read between wr and ret.
  always_ff @(posedge CLK) begin
    if (|grant) begin
      queue_mem[wr_ptr[P-1:0]] <= '{addr: grant_addr, id: grant_id};
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr               <= '0;
      iss_ptr              <= '0;
      ret_ptr              <= '0;
      cooldown             <= '0;
      SB_PREFETCH_COMMITED <= '0;
      REFILL_DATA          <= '0;
      PROTOCOL_ERR         <= 1'b0;
    end else if (ENB) begin
      cooldown <= grant;
      if (|grant) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue_fire) begin
        iss_ptr <= iss_ptr + 1'b1;
      end
      if (resp_fire) begin
        // Commits go to the original owner even if the buffer was
        // reassigned meanwhile; the buffer's own counter drops stale data.
        SB_PREFETCH_COMMITED <= id_to_onehot(queue_mem[ret_ptr[P-1:0]].id);
        REFILL_DATA          <= L2_RESP_DATA;
        ret_ptr              <= ret_ptr + 1'b1;
      end else begin
        SB_PREFETCH_COMMITED <= '0;
      end
      if (resp_stray) begin
        PROTOCOL_ERR <= 1'b1;
      end
    end
  end

endmodule : prefetch_queue_responder
`default_nettype wire

// File: tb/tb_prefetch_queue_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_prefetch_queue_responder                                            |
// | Directed stimulus with a scoreboard: each response driven pushes the   |
// | expected commit; a negedge monitor pops and compares commit pulses.    |
// | Honours PREFETCH_QUEUE_RR_EN for the expected arbitration order.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_prefetch_queue_responder;

  localparam int AW = 5;
  localparam int DW = 256;
  localparam int NB = 4;

  logic           CLK = 1'b0;
  logic           RSTN;
  logic           ENB;
  logic [NB-1:0]  SB_PREFETCH_VALID;
  logic [NB*AW-1:0] SB_NEXT_REQ;
  logic [NB-1:0]  SB_PREFETCH_REQUESTED;
  logic [NB-1:0]  SB_PREFETCH_COMMITED;
  logic [DW-1:0]  REFILL_DATA;
  logic           L2_REQ_VALID;
  logic           L2_REQ_READY;
  logic [AW-1:0]  L2_REQ_ADDR;
  logic           L2_RESP_VALID;
  logic [DW-1:0]  L2_RESP_DATA;
  logic           PROTOCOL_ERR;

  prefetch_queue_responder dut (
    .CLK                   (CLK),
    .RSTN                  (RSTN),
    .ENB                   (ENB),
    .SB_PREFETCH_VALID     (SB_PREFETCH_VALID),
    .SB_NEXT_REQ           (SB_NEXT_REQ),
    .SB_PREFETCH_REQUESTED (SB_PREFETCH_REQUESTED),
    .SB_PREFETCH_COMMITED  (SB_PREFETCH_COMMITED),
    .REFILL_DATA           (REFILL_DATA),
    .L2_REQ_VALID          (L2_REQ_VALID),
    .L2_REQ_READY          (L2_REQ_READY),
    .L2_REQ_ADDR           (L2_REQ_ADDR),
    .L2_RESP_VALID         (L2_RESP_VALID),
    .L2_RESP_DATA          (L2_RESP_DATA),
    .PROTOCOL_ERR          (PROTOCOL_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    int            id;
  } req_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } cmt_t;

  req_t queued_q[$];   // granted, not yet issued
  req_t out_q[$];      // issued, awaiting response
  cmt_t exp_q[$];      // expected commit pulses

  int   errors    = 0;
  int   checks    = 0;
  int   cycle_cnt = 0;
  logic err_model = 1'b0;
  logic [AW-1:0] sb_addr [NB];

  always_comb begin
    SB_NEXT_REQ = '0;
    for (int i = 0; i < NB; i++) begin
      SB_NEXT_REQ[i*AW +: AW] = sb_addr[i];
    end
  end

  always @(posedge CLK) cycle_cnt = cycle_cnt + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs 1ns
  // later, then advance the reference queues. resp_mode: 0 none,
  // 1 forced, 2 only when the model has something outstanding.
  task automatic cyc(input logic en, input logic [NB-1:0] valid, input logic ready,
                     input int resp_mode, input logic [DW-1:0] rdata,
                     input logic [NB-1:0] exp_grant);
    logic do_resp;
    req_t r;
    cmt_t c;
    @(negedge CLK);
    do_resp = (resp_mode == 1) || (resp_mode == 2 && out_q.size() > 0);
    ENB               = en;
    SB_PREFETCH_VALID = valid;
    L2_REQ_READY      = ready;
    L2_RESP_VALID     = do_resp;
    L2_RESP_DATA      = rdata;
    #1;
    check("grant", DW'(SB_PREFETCH_REQUESTED), DW'(exp_grant));
    check("l2_req_valid", DW'(L2_REQ_VALID), DW'(en && queued_q.size() > 0));
    if (en && queued_q.size() > 0) begin
      check("l2_req_addr", DW'(L2_REQ_ADDR), DW'(queued_q[0].addr));
    end
    check("protocol_err", DW'(PROTOCOL_ERR), DW'(err_model));
    if (en) begin
      if (do_resp) begin
        if (out_q.size() > 0) begin
          r      = out_q.pop_front();
          c.id   = r.id;
          c.data = rdata;
          c.due  = cycle_cnt + 1;
          exp_q.push_back(c);
        end else begin
          err_model = 1'b1;
        end
      end
      if (ready && queued_q.size() > 0) begin
        out_q.push_back(queued_q.pop_front());
      end
      for (int i = 0; i < NB; i++) begin
        if (exp_grant[i]) begin
          r.addr = sb_addr[i];
          r.id   = i;
          queued_q.push_back(r);
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    return {8{32'hC0DE0000 + 32'(k)}};
  endfunction

  // Commit monitor.
  always @(negedge CLK) begin
    cmt_t c;
    if (RSTN) begin
      if (exp_q.size() > 0 && exp_q[0].due == cycle_cnt) begin
        c = exp_q.pop_front();
        check("commit_onehot", DW'(SB_PREFETCH_COMMITED), DW'(1 << c.id));
        check("refill_data", REFILL_DATA, c.data);
      end else if (SB_PREFETCH_COMMITED != '0) begin
        check("unexpected_commit", DW'(SB_PREFETCH_COMMITED), '0);
      end
    end
  end

  initial begin
    #200000;
    errors = errors + 1;
    $display("FAIL timeout: actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  logic [NB-1:0] arb_exp  [5];
  logic [NB-1:0] fill_exp [4];
  logic [NB-1:0] fill_regrant;
  logic [NB-1:0] ord_valid [11];
  logic          ord_ready [11];
  int            dcount;

  initial begin
`ifdef PREFETCH_QUEUE_RR_EN
    arb_exp      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fill_exp     = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    fill_regrant = 4'b1000;
`else
    arb_exp      = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    fill_exp     = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    fill_regrant = 4'b0001;
`endif
    ord_valid = '{4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0000,
                  4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ord_ready = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dcount = 0;

    RSTN = 1'b0; ENB = 1'b1; SB_PREFETCH_VALID = '0; L2_REQ_READY = 1'b0;
    L2_RESP_VALID = 1'b0; L2_RESP_DATA = '0;
    sb_addr = '{5'h01, 5'h0B, 5'h12, 5'h1F};

    // Reset state.
    repeat (2) @(negedge CLK);
    #1;
    check("rst_l2_req_valid", DW'(L2_REQ_VALID), '0);
    check("rst_commit", DW'(SB_PREFETCH_COMMITED), '0);
    check("rst_refill_data", REFILL_DATA, '0);
    check("rst_protocol_err", DW'(PROTOCOL_ERR), '0);
    check("rst_grant", DW'(SB_PREFETCH_REQUESTED), '0);
    @(negedge CLK);
    RSTN = 1'b1;

    // Arbitration, all buffers valid, with L2 draining continuously.
    for (int k = 0; k < 5; k++) cyc(1'b1, 4'b1111, 1'b1, 2, pat(dcount++), arb_exp[k]);
    repeat (4) cyc(1'b1, 4'b0000, 1'b1, 2, pat(dcount++), 4'b0000);

    // Single request from buffer 1, response three cycles after grant.
    sb_addr[1] = 5'h0A;
    cyc(1'b1, 4'b0010, 1'b1, 0, '0, 4'b0010);
    cyc(1'b1, 4'b0000, 1'b1, 0, '0, 4'b0000);
    cyc(1'b1, 4'b0000, 1'b1, 0, '0, 4'b0000);
    cyc(1'b1, 4'b0000, 1'b1, 1, {8{32'hDEADBEEF}}, 4'b0000);
    cyc(1'b1, 4'b0000, 1'b1, 0, '0, 4'b0000);

    // Disabled: no grant, response ignored.
    cyc(1'b0, 4'b0001, 1'b1, 1, pat(99), 4'b0000);
    cyc(1'b1, 4'b0000, 1'b1, 0, '0, 4'b0000);

    // Cooldown: buffer 2 alone gets every other cycle.
    cyc(1'b1, 4'b0100, 1'b1, 0, '0, 4'b0100);
    cyc(1'b1, 4'b0100, 1'b1, 0, '0, 4'b0000);
    cyc(1'b1, 4'b0100, 1'b1, 2, pat(dcount++), 4'b0100);
    cyc(1'b1, 4'b0100, 1'b1, 2, pat(dcount++), 4'b0000);
    repeat (3) cyc(1'b1, 4'b0000, 1'b1, 2, pat(dcount++), 4'b0000);

    // Fill with L2 stalled, then free exactly one slot.
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'b1111, 1'b0, 0, '0, fill_exp[k]);
    repeat (2) cyc(1'b1, 4'b1111, 1'b0, 0, '0, 4'b0000);
    cyc(1'b1, 4'b1111, 1'b1, 0, '0, 4'b0000);
    cyc(1'b1, 4'b1111, 1'b0, 1, pat(dcount++), 4'b0000);
    cyc(1'b1, 4'b1111, 1'b0, 0, '0, fill_regrant);
    cyc(1'b1, 4'b1111, 1'b0, 0, '0, 4'b0000);
    repeat (8) cyc(1'b1, 4'b0000, 1'b1, 2, pat(dcount++), 4'b0000);

    // Ordering across pointer wrap with varying READY.
    for (int k = 0; k < 11; k++) begin
      if (k == 6) sb_addr = '{5'h05, 5'h15, 5'h0E, 5'h1C};
      cyc(1'b1, ord_valid[k], ord_ready[k], 2, pat(100 + k), ord_valid[k]);
    end
    repeat (6) cyc(1'b1, 4'b0000, 1'b1, 2, pat(dcount++), 4'b0000);

    // Stray response with nothing outstanding.
    cyc(1'b1, 4'b0000, 1'b0, 1, pat(200), 4'b0000);
    cyc(1'b1, 4'b0000, 1'b0, 0, '0, 4'b0000);

    // Reset with three requests outstanding.
    cyc(1'b1, 4'b0001, 1'b1, 0, '0, 4'b0001);
    cyc(1'b1, 4'b0010, 1'b1, 0, '0, 4'b0010);
    cyc(1'b1, 4'b0100, 1'b1, 0, '0, 4'b0100);
    cyc(1'b1, 4'b0000, 1'b1, 0, '0, 4'b0000);
    @(negedge CLK);
    RSTN = 1'b0;
    SB_PREFETCH_VALID = '0;
    #1;
    check("midrst_l2_req_valid", DW'(L2_REQ_VALID), '0);
    check("midrst_commit", DW'(SB_PREFETCH_COMMITED), '0);
    check("midrst_refill_data", REFILL_DATA, '0);
    check("midrst_protocol_err", DW'(PROTOCOL_ERR), '0);
    queued_q.delete();
    out_q.delete();
    err_model = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(1'b1, 4'b0000, 1'b0, 1, pat(300), 4'b0000);
    cyc(1'b1, 4'b0000, 1'b0, 0, '0, 4'b0000);

    repeat (2) @(negedge CLK);
    check("pending_commits", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prefetch_queue_responder
`default_nettype wire
